// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the parametrised synchronous FIFO.
package fifo_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_OTHER = 2'd1,
    ST_FULL  = 2'd2
  } fifo_state_t;

  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Occupancy needs one extra bit to represent DEPTH itself.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// DEPTH x DATA_W register array: synchronous write port, asynchronous read port.
module fifo_mem_dp
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32
) (
  input  logic                          clock,
  input  logic                          we,
  input  logic [fifo_ptr_w(DEPTH)-1:0]  waddr,
  input  logic [DATA_W-1:0]             wdata,
  input  logic [fifo_ptr_w(DEPTH)-1:0]  raddr,
  output logic [DATA_W-1:0]             rdata
);

  logic [DEPTH-1:0][DATA_W-1:0] mem;

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with almost flags and sticky OVF/UDF.
// Define FIFO_SHOWAHEAD_EN for first-word-fall-through reads.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 32,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic                          CLOCK,
  input  logic                          RESET_N,
  input  logic                          CLEAR_N,
  input  logic                          WRITE,
  input  logic                          READ,
  input  logic [DATA_W-1:0]             DATA_IN,
  output logic [DATA_W-1:0]             DATA_OUT,
  output logic                          F_FULL_N,
  output logic                          F_EMPTY_N,
  output logic                          F_AFULL_N,
  output logic                          F_AEMPTY_N,
  output logic [fifo_cnt_w(DEPTH)-1:0]  USE_DW,
  output logic                          OVF,
  output logic                          UDF
);

  localparam int PW = fifo_ptr_w(DEPTH);
  localparam int CW = fifo_cnt_w(DEPTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);

  fifo_state_t       state, nxt_state;
  logic [PW-1:0]     wptr, rptr;
  logic [CW-1:0]     cnt, nxt_cnt;
  logic              push, pop, ovf_set, udf_set;
  logic [DATA_W-1:0] rd_data;

  fifo_mem_dp #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clock (CLOCK),
    .we    (push),
    .waddr (wptr),
    .wdata (DATA_IN),
    .raddr (rptr),
    .rdata (rd_data)
  );

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N)      state <= ST_EMPTY;
    else if (!CLEAR_N) state <= ST_EMPTY;
    else               state <= nxt_state;
  end

  // Push/pop decisions come from the state alone so the boundary cases stay explicit.
  always_comb begin
    nxt_state = state;
    push      = 1'b0;
    pop       = 1'b0;
    ovf_set   = 1'b0;
    udf_set   = 1'b0;
    case (state)
      ST_EMPTY: begin
        udf_set = READ;
        if (WRITE) begin
          push      = 1'b1;
          nxt_state = ST_OTHER;
        end
      end
      ST_OTHER: begin
        push = WRITE;
        pop  = READ;
        if (WRITE && !READ && cnt == CNT_LAST) nxt_state = ST_FULL;
        if (READ && !WRITE && cnt == CNT_ONE)  nxt_state = ST_EMPTY;
      end
      ST_FULL: begin
        if (READ) begin
          pop  = 1'b1;
          push = WRITE;
          if (!WRITE) nxt_state = ST_OTHER;
        end else begin
          ovf_set = WRITE;
        end
      end
      default: nxt_state = ST_EMPTY;
    endcase
    case ({push, pop})
      2'b10:   nxt_cnt = cnt + CNT_ONE;
      2'b01:   nxt_cnt = cnt - CNT_ONE;
      default: nxt_cnt = cnt;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      wptr       <= '0;
      rptr       <= '0;
      cnt        <= '0;
      F_FULL_N   <= 1'b1;
      F_EMPTY_N  <= 1'b0;
      F_AFULL_N  <= 1'b1;
      F_AEMPTY_N <= 1'b0;
      OVF        <= 1'b0;
      UDF        <= 1'b0;
    end else if (!CLEAR_N) begin
      wptr       <= '0;
      rptr       <= '0;
      cnt        <= '0;
      F_FULL_N   <= 1'b1;
      F_EMPTY_N  <= 1'b0;
      F_AFULL_N  <= 1'b1;
      F_AEMPTY_N <= 1'b0;
      OVF        <= 1'b0;
      UDF        <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      cnt        <= nxt_cnt;
      F_FULL_N   <= (nxt_cnt != CNT_FULL);
      F_EMPTY_N  <= (nxt_cnt != '0);
      F_AFULL_N  <= (nxt_cnt < CNT_AF);
      F_AEMPTY_N <= (nxt_cnt > CNT_AE);
      OVF        <= OVF | ovf_set;
      UDF        <= UDF | udf_set;
    end
  end

  assign USE_DW = cnt;

`ifdef FIFO_SHOWAHEAD_EN
  assign DATA_OUT = F_EMPTY_N ? rd_data : '0;
`else
  logic [DATA_W-1:0] dout_q;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N)      dout_q <= '0;
    else if (!CLEAR_N) dout_q <= '0;
    else if (pop)      dout_q <= rd_data;
  end

  assign DATA_OUT = dout_q;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param with a queue-based reference model checked every cycle.
module tb_fifo_sync_param;
  localparam int DEPTH = 32;

  logic       CLOCK = 1'b0;
  logic       RESET_N, CLEAR_N, WRITE, READ;
  logic [7:0] DATA_IN, DATA_OUT;
  logic       F_FULL_N, F_EMPTY_N, F_AFULL_N, F_AEMPTY_N, OVF, UDF;
  logic [5:0] USE_DW;

  int checks = 0;
  int errors = 0;

  fifo_sync_param dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .CLEAR_N(CLEAR_N), .WRITE(WRITE), .READ(READ),
    .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .F_FULL_N(F_FULL_N), .F_EMPTY_N(F_EMPTY_N),
    .F_AFULL_N(F_AFULL_N), .F_AEMPTY_N(F_AEMPTY_N), .USE_DW(USE_DW), .OVF(OVF), .UDF(UDF)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue plus sticky flags and the last popped word.
  logic [7:0] q[$];
  logic       m_ovf, m_udf;
  logic [7:0] m_dout;

  always @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N || !CLEAR_N) begin
      q.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_dout = 8'h00;
    end else begin
      bit do_pop, do_push;
      if (READ && q.size() == 0) m_udf = 1'b1;
      if (WRITE && !READ && q.size() == DEPTH) m_ovf = 1'b1;
      do_pop  = READ && q.size() > 0;
      do_push = WRITE && (q.size() < DEPTH || READ);
      if (do_pop)  m_dout = q.pop_front();
      if (do_push) q.push_back(DATA_IN);
    end
  end

  function automatic logic [7:0] exp_dout();
`ifdef FIFO_SHOWAHEAD_EN
    return (q.size() > 0) ? q[0] : 8'h00;
`else
    return m_dout;
`endif
  endfunction

  always @(negedge CLOCK) begin
    chk("m_dout",     DATA_OUT,   exp_dout());
    chk("m_use_dw",   USE_DW,     q.size());
    chk("m_full_n",   F_FULL_N,   q.size() != DEPTH);
    chk("m_empty_n",  F_EMPTY_N,  q.size() != 0);
    chk("m_afull_n",  F_AFULL_N,  q.size() < DEPTH - 4);
    chk("m_aempty_n", F_AEMPTY_N, q.size() > 4);
    chk("m_ovf",      OVF,        m_ovf);
    chk("m_udf",      UDF,        m_udf);
  end

  task automatic step(input logic w, input logic r, input logic [7:0] d);
    WRITE = w; READ = r; DATA_IN = d;
    @(negedge CLOCK);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dout"},     DATA_OUT,   0);
    chk({tag, "_full_n"},   F_FULL_N,   1);
    chk({tag, "_empty_n"},  F_EMPTY_N,  0);
    chk({tag, "_afull_n"},  F_AFULL_N,  1);
    chk({tag, "_aempty_n"}, F_AEMPTY_N, 0);
    chk({tag, "_use_dw"},   USE_DW,     0);
    chk({tag, "_ovf"},      OVF,        0);
    chk({tag, "_udf"},      UDF,        0);
  endtask

  initial begin
    RESET_N = 1'b0; CLEAR_N = 1'b1; WRITE = 1'b0; READ = 1'b0; DATA_IN = 8'h00;
    @(negedge CLOCK);
    chk_reset_vals("rst");
    step(0, 0, 8'h00);
    RESET_N = 1'b1;

`ifdef FIFO_SHOWAHEAD_EN
    step(1, 0, 8'h3C);
    chk("sa_empty_n", F_EMPTY_N, 1);
    chk("sa_head",    DATA_OUT,  8'h3C);
    step(0, 1, 8'h00);
    chk("sa_dout0",   DATA_OUT,  8'h00);
    chk("sa_empty",   F_EMPTY_N, 0);
`else
    // Fill and threshold crossings
    for (int i = 0; i < 32; i++) begin
      step(1, 0, 8'(i));
      if (i == 0)  chk("fill_empty_n_1", F_EMPTY_N, 1);
      if (i == 3)  chk("fill_aempty_n_4", F_AEMPTY_N, 0);
      if (i == 4)  chk("fill_aempty_n_5", F_AEMPTY_N, 1);
      if (i == 26) chk("fill_afull_n_27", F_AFULL_N, 1);
      if (i == 27) chk("fill_afull_n_28", F_AFULL_N, 0);
    end
    chk("fill_full_n", F_FULL_N, 0);
    chk("fill_use_dw", USE_DW, 32);

    // Overflow, then drain in order
    step(1, 0, 8'hAA);
    chk("ovf_flag", OVF, 1);
    chk("ovf_use_dw", USE_DW, 32);
    for (int i = 0; i < 32; i++) begin
      step(0, 1, 8'h00);
      chk("drain_data", DATA_OUT, i);
    end
    chk("drain_empty_n", F_EMPTY_N, 0);

    // Underflow, then flush
    step(0, 1, 8'h00);
    chk("udf_flag", UDF, 1);
    chk("udf_dout_hold", DATA_OUT, 8'h1F);
    chk("udf_use_dw", USE_DW, 0);
    CLEAR_N = 1'b0;
    step(0, 0, 8'h00);
    CLEAR_N = 1'b1;
    chk("clr_udf", UDF, 0);
    chk("clr_ovf", OVF, 0);

    // Wrap-around across the pointer boundary
    for (int i = 0; i < 20; i++) step(1, 0, 8'(8'h20 + i));
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 8'h00);
      chk("wrap1_data", DATA_OUT, 8'h20 + i);
    end
    for (int i = 0; i < 20; i++) step(1, 0, 8'(8'h40 + i));
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 8'h00);
      chk("wrap2_data", DATA_OUT, 8'h40 + i);
    end
    chk("wrap_use_dw", USE_DW, 0);

    // Simultaneous read+write at full and at empty
    for (int i = 0; i < 32; i++) step(1, 0, 8'(8'h60 + i));
    step(1, 1, 8'h77);
    chk("simf_use_dw", USE_DW, 32);
    chk("simf_full_n", F_FULL_N, 0);
    chk("simf_ovf", OVF, 0);
    chk("simf_dout", DATA_OUT, 8'h60);
    for (int i = 0; i < 32; i++) begin
      step(0, 1, 8'h00);
      chk("simf_drain", DATA_OUT, (i < 31) ? 8'h61 + i : 8'h77);
    end
    step(1, 1, 8'h55);
    chk("sime_use_dw", USE_DW, 1);
    chk("sime_udf", UDF, 1);
    chk("sime_dout_hold", DATA_OUT, 8'h77);
    step(0, 1, 8'h00);
    chk("sime_data", DATA_OUT, 8'h55);
    CLEAR_N = 1'b0;
    step(0, 0, 8'h00);
    CLEAR_N = 1'b1;

    // Asynchronous reset in mid-operation
    for (int i = 0; i < 10; i++) step(1, 0, 8'(8'h80 + i));
    WRITE = 1'b0;
    chk("mid_use_dw", USE_DW, 10);
    #2 RESET_N = 1'b0;
    #1 chk_reset_vals("async");
    @(negedge CLOCK);
    RESET_N = 1'b1;
    step(1, 0, 8'h12);
    step(0, 1, 8'h00);
    chk("post_rst_data", DATA_OUT, 8'h12);
`endif

    step(0, 0, 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
